// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and hands each returned word with its PC to decode through a one-entry
// valid/ready output register. Redirects squash any fetch still in flight.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic {StFetch, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        discard_q, discard_d;
    logic        started_q;

    logic        space;
    logic        issue;
    logic        fire;
    logic        load;

    // Output register can take a new word if empty or being drained this cycle.
    assign space = !id_valid_q || id_ready;
    // Fetch would be issued this cycle, ignoring the redirect mask.
    assign issue = (state_q == StFetch) && started_q && space;
    // A grant alongside a redirect still counts: the memory owes us a response.
    assign fire  = issue && imem_gnt;
    assign load  = (state_q == StWait) && imem_rvalid && !discard_q && !redirect_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (fire)        state_d = StWait;
            StWait:  if (imem_rvalid) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    // FSM outputs: request is suppressed during a redirect cycle.
    always_comb begin
        imem_req  = issue && !redirect_valid;
        imem_addr = pc_q;
    end

    // Datapath next-state: PC, in-flight PC, discard flag and output register.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;

        if (fire) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        if (state_q == StFetch) begin
            if (fire && redirect_valid) discard_d = 1'b1;
        end else begin
            if (imem_rvalid)         discard_d = 1'b0;
            else if (redirect_valid) discard_d = 1'b1;
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'd3;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (load) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc_q;
        end else if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 32'h0000_0000;
            started_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            started_q  <= 1'b1;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch flow, backpressure, redirects, PC wrap, reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    // Second instance for the PC wrap case, driven by a zero-wait memory.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_addrs[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INSTR(32'h0000_0013)
    ) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_gnt      (w_gnt),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (32'h1111_1111),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .id_valid      (w_valid),
        .id_ready      (1'b1),
        .id_instr      (w_instr),
        .id_pc         (w_pc)
    );

    assign w_gnt = w_req;

    always @(posedge clk or posedge rst) begin
        if (rst) w_rvalid <= 1'b0;
        else     w_rvalid <= w_req & w_gnt;
    end

    always @(posedge clk) begin
        if (!rst && w_req && w_gnt) w_addrs.push_back(w_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and step past the held-off cycle so a request is pending.
    task automatic do_reset();
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("req_held_after_release", imem_req, 1'b0);
        tick();
    endtask

    // Grant the pending request, then return data one cycle later.
    task automatic fetch_one(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        // ---- reset values ----
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        tick();
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // ---- zero-wait fetch stream ----
        do_reset();
        id_ready = 1'b1;
        #1;
        check("t1_req0", imem_req, 1'b1);
        check("t1_addr0", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #1;
        check("t1_wait_req", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("t1_valid0", id_valid, 1'b1);
        check("t1_pc0", id_pc, 32'h0);
        check("t1_instr0", id_instr, 32'h0050_0093);
        check("t1_req1", imem_req, 1'b1);
        check("t1_addr1", imem_addr, 32'h4);
        fetch_one(32'h00A0_0113);
        check("t1_pc1", id_pc, 32'h4);
        check("t1_instr1", id_instr, 32'h00A0_0113);
        check("t1_addr2", imem_addr, 32'h8);
        check("t1_req2", imem_req, 1'b1);
        check("wrap_cnt", w_addrs.size() >= 2, 1'b1);
        check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
        check("wrap_addr1", w_addrs[1], 32'h0);

        // ---- backpressure ----
        do_reset();
        id_ready = 1'b0;
        fetch_one(32'hAAAA_0001);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", id_valid, 1'b1);
            check("bp_pc", id_pc, 32'h0);
            check("bp_instr", id_instr, 32'hAAAA_0001);
            check("bp_req", imem_req, 1'b0);
            tick();
        end
        id_ready = 1'b1;
        #1;
        check("bp_release_req", imem_req, 1'b1);
        check("bp_release_addr", imem_addr, 32'h4);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        id_ready = 1'b0;
        #1;
        check("bp_drained", id_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBBBB_0002;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("bp_pc1", id_pc, 32'h4);
        check("bp_instr1", id_instr, 32'hBBBB_0002);
        tick();
        check("bp_hold_req", imem_req, 1'b0);
        check("bp_hold_pc", id_pc, 32'h4);

        // ---- redirect while waiting for a response ----
        do_reset();
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        check("rw_req_in_redirect", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("rw_stale_dropped", id_valid, 1'b0);
        check("rw_req", imem_req, 1'b1);
        check("rw_addr", imem_addr, 32'h100);
        fetch_one(32'hCCCC_0003);
        check("rw_valid", id_valid, 1'b1);
        check("rw_pc", id_pc, 32'h100);
        check("rw_instr", id_instr, 32'hCCCC_0003);

        // ---- redirect coincident with grant at addr 8 ----
        do_reset();
        id_ready = 1'b1;
        fetch_one(32'h0000_0001);
        fetch_one(32'h0000_0002);
        check("rg_addr8", imem_addr, 32'h8);
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        check("rg_req_masked", imem_req, 1'b0);
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rg_valid_cleared", id_valid, 1'b0);
        check("rg_instr_nop", id_instr, NOP);
        check("rg_wait_req", imem_req, 1'b0);
        check("rg_pc_target", imem_addr, 32'h40);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0008;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("rg_stale_dropped", id_valid, 1'b0);
        check("rg_req", imem_req, 1'b1);
        check("rg_addr", imem_addr, 32'h40);
        fetch_one(32'hDDDD_0004);
        check("rg_pc", id_pc, 32'h40);
        check("rg_instr", id_instr, 32'hDDDD_0004);

        // ---- asynchronous reset mid-operation ----
        do_reset();
        id_ready = 1'b0;
        fetch_one(32'hEEEE_0005);
        check("ar_pre_valid", id_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("ar_valid", id_valid, 1'b0);
        check("ar_instr", id_instr, NOP);
        check("ar_pc", id_pc, 32'h0);
        tick();
        rst      = 1'b0;
        id_ready = 1'b1;
        tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        // Reset during WAIT, then a late response while back in FETCH.
        rst = 1'b1;
        #1;
        check("ar_wait_req", imem_req, 1'b0);
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("ar_late_ignored", id_valid, 1'b0);
        check("ar_first_req", imem_req, 1'b1);
        check("ar_first_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
